// File: rtl/decode_sequencer.sv
// decode_sequencer: orders redirect restarts (prefetch reset, then held decode
// reset, then refill) and folds sticky decode faults into one exception request.
module decode_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_EIP    = 32'h0000FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_req,
  input  logic [31:0] flush_eip,
  output logic        flush_ack,
  output logic        pr_reset,
  output logic [31:0] prefetch_eip,
  output logic        dec_reset,
  input  logic [3:0]  fetch_valid,
  input  logic        dec_ready,
  input  logic [31:0] eip,
  input  logic        dec_gp_fault,
  input  logic        dec_ud_fault,
  input  logic        dec_pf_fault,
  output logic        exc_req,
  output logic [7:0]  exc_vector,
  output logic [31:0] exc_eip,
  input  logic        exc_ack,
  output logic        seq_busy,
  output logic [31:0] dec_instr_count
);

  typedef enum logic [2:0] {
    S_RUN,
    S_FLUSH,
    S_REFILL,
    S_FAULT,
    S_PARKED
  } state_e;

  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] VEC_PF    = 8'd14;
  localparam logic [7:0] VEC_GP    = 8'd13;
  localparam logic [7:0] VEC_UD    = 8'd6;

  state_e      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [31:0] prefetch_eip_q, prefetch_eip_d;
  logic        pr_reset_q, pr_reset_d;
  logic        flush_ack_q, flush_ack_d;
  logic        dec_reset_q, dec_reset_d;
  logic        exc_req_q, exc_req_d;
  logic [7:0]  exc_vector_q, exc_vector_d;
  logic [31:0] exc_eip_q, exc_eip_d;
  logic        seq_busy_q, seq_busy_d;
  logic [31:0] cnt_q, cnt_d;

  logic        fault_any;
  logic [7:0]  fault_vec;

  assign fault_any = dec_gp_fault | dec_ud_fault | dec_pf_fault;

  // Several faults may be sticky at once; PF outranks GP outranks UD.
  always_comb begin
    fault_vec = VEC_UD;
    if (dec_pf_fault) begin
      fault_vec = VEC_PF;
    end else if (dec_gp_fault) begin
      fault_vec = VEC_GP;
    end
  end

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    prefetch_eip_d = prefetch_eip_q;
    pr_reset_d     = 1'b0;
    flush_ack_d    = 1'b0;
    dec_reset_d    = 1'b0;
    exc_req_d      = exc_req_q;
    exc_vector_d   = exc_vector_q;
    exc_eip_d      = exc_eip_q;

    if (flush_req) begin
      state_d        = S_FLUSH;
      fcnt_d         = FCNT_INIT;
      prefetch_eip_d = flush_eip;
      pr_reset_d     = 1'b1;
      flush_ack_d    = 1'b1;
      dec_reset_d    = 1'b1;
      exc_req_d      = 1'b0;
    end else begin
      unique case (state_q)
        S_FLUSH: begin
          if (fcnt_q == 4'd0) begin
            state_d = S_REFILL;
          end else begin
            fcnt_d      = fcnt_q - 4'd1;
            dec_reset_d = 1'b1;
          end
        end
        S_REFILL, S_RUN: begin
          if (fault_any) begin
            state_d      = S_FAULT;
            exc_req_d    = 1'b1;
            exc_vector_d = fault_vec;
            exc_eip_d    = eip;
          end else if (state_q == S_REFILL &&
                       fetch_valid != 4'd0) begin
            state_d = S_RUN;
          end
        end
        S_FAULT: begin
          if (exc_ack) begin
            state_d   = S_PARKED;
            exc_req_d = 1'b0;
          end
        end
        S_PARKED: begin
          state_d = S_PARKED;
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end

    seq_busy_d = (state_d != S_RUN);
  end

  // Counting depends only on the current state, so a flush accepted this
  // cycle does not swallow an instruction decode already emitted.
  always_comb begin
    cnt_d = cnt_q;
    if (dec_ready &&
        (state_q == S_RUN || state_q == S_REFILL)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      fcnt_q         <= 4'd0;
      prefetch_eip_q <= RESET_EIP;
      pr_reset_q     <= 1'b0;
      flush_ack_q    <= 1'b0;
      dec_reset_q    <= 1'b0;
      exc_req_q      <= 1'b0;
      exc_vector_q   <= 8'd0;
      exc_eip_q      <= 32'd0;
      seq_busy_q     <= 1'b0;
      cnt_q          <= 32'd0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      prefetch_eip_q <= prefetch_eip_d;
      pr_reset_q     <= pr_reset_d;
      flush_ack_q    <= flush_ack_d;
      dec_reset_q    <= dec_reset_d;
      exc_req_q      <= exc_req_d;
      exc_vector_q   <= exc_vector_d;
      exc_eip_q      <= exc_eip_d;
      seq_busy_q     <= seq_busy_d;
      cnt_q          <= cnt_d;
    end
  end

  assign flush_ack       = flush_ack_q;
  assign pr_reset        = pr_reset_q;
  assign prefetch_eip    = prefetch_eip_q;
  assign dec_reset       = dec_reset_q;
  assign exc_req         = exc_req_q;
  assign exc_vector      = exc_vector_q;
  assign exc_eip         = exc_eip_q;
  assign seq_busy        = seq_busy_q;
  assign dec_instr_count = cnt_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed + random stimulus, per-cycle scoreboard
// against a flag-based behavioural model of the restart/fault sequencing.
module tb_decode_sequencer;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam logic [31:0] RESET_EIP    = 32'h0000FFF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_eip = '0;
  logic        flush_ack;
  logic        pr_reset;
  logic [31:0] prefetch_eip;
  logic        dec_reset;
  logic [3:0]  fetch_valid = '0;
  logic        dec_ready = 1'b0;
  logic [31:0] eip = '0;
  logic        dec_gp_fault = 1'b0;
  logic        dec_ud_fault = 1'b0;
  logic        dec_pf_fault = 1'b0;
  logic        exc_req;
  logic [7:0]  exc_vector;
  logic [31:0] exc_eip;
  logic        exc_ack = 1'b0;
  logic        seq_busy;
  logic [31:0] dec_instr_count;

  decode_sequencer #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .RESET_EIP(RESET_EIP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_req(flush_req),
    .flush_eip(flush_eip),
    .flush_ack(flush_ack),
    .pr_reset(pr_reset),
    .prefetch_eip(prefetch_eip),
    .dec_reset(dec_reset),
    .fetch_valid(fetch_valid),
    .dec_ready(dec_ready),
    .eip(eip),
    .dec_gp_fault(dec_gp_fault),
    .dec_ud_fault(dec_ud_fault),
    .dec_pf_fault(dec_pf_fault),
    .exc_req(exc_req),
    .exc_vector(exc_vector),
    .exc_eip(exc_eip),
    .exc_ack(exc_ack),
    .seq_busy(seq_busy),
    .dec_instr_count(dec_instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pr;
    bit          dr;
    bit          xr;
    bit          busy;
    logic [31:0] pe;
    logic [7:0]  vec;
    logic [31:0] xeip;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: how many dec_reset cycles remain, plus what we are waiting on.
  int          m_flush_left;
  bit          m_refill, m_fault, m_park, m_pulse;
  logic [31:0] m_pe, m_xeip, m_cnt;
  logic [7:0]  m_vec;

  function automatic void model_reset();
    m_flush_left = 0;
    m_refill = 0;
    m_fault  = 0;
    m_park   = 0;
    m_pulse  = 0;
    m_pe     = RESET_EIP;
    m_xeip   = '0;
    m_vec    = '0;
    m_cnt    = '0;
  endfunction

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit fr, logic [31:0] fe,
                                     logic [3:0] fv, bit rdy,
                                     logic [31:0] ei, bit gp, bit ud,
                                     bit pf, bit ack);
    bit   counting;
    exp_t e;
    counting = (m_flush_left == 0) && !m_fault && !m_park;
    if (counting && rdy) m_cnt = m_cnt + 32'd1;
    m_pulse = 0;
    if (fr) begin
      m_flush_left = FLUSH_CYCLES;
      m_refill = 0;
      m_fault  = 0;
      m_park   = 0;
      m_pe     = fe;
      m_pulse  = 1;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_refill = 1;
    end else if (m_fault) begin
      if (ack) begin
        m_fault = 0;
        m_park  = 1;
      end
    end else if (!m_park) begin
      if (gp || ud || pf) begin
        m_fault  = 1;
        m_refill = 0;
        m_vec    = pf ? 8'd14 : (gp ? 8'd13 : 8'd6);
        m_xeip   = ei;
      end else if (m_refill && fv != 0) begin
        m_refill = 0;
      end
    end
    e.pr   = m_pulse;
    e.dr   = (m_flush_left > 0);
    e.xr   = m_fault;
    e.busy = (m_flush_left > 0) || m_refill || m_fault || m_park;
    e.pe   = m_pe;
    e.vec  = m_vec;
    e.xeip = m_xeip;
    e.cnt  = m_cnt;
    sbq.push_back(e);
  endfunction

  task automatic apply(bit fr, logic [31:0] fe, logic [3:0] fv, bit rdy,
                       logic [31:0] ei, bit gp, bit ud, bit pf, bit ack);
    flush_req    = fr;
    flush_eip    = fe;
    fetch_valid  = fv;
    dec_ready    = rdy;
    eip          = ei;
    dec_gp_fault = gp;
    dec_ud_fault = ud;
    dec_pf_fault = pf;
    exc_ack      = ack;
    model_step(fr, fe, fv, rdy, ei, gp, ud, pf, ack);
  endtask

  task automatic drive(bit fr, logic [31:0] fe, logic [3:0] fv, bit rdy,
                       logic [31:0] ei, bit gp, bit ud, bit pf, bit ack);
    @(negedge clk);
    apply(fr, fe, fv, rdy, ei, gp, ud, pf, ack);
  endtask

  task automatic idle(int n, logic [3:0] fv);
    for (int i = 0; i < n; i++) drive(0, '0, fv, 0, '0, 0, 0, 0, 0);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("pr_reset", 32'(pr_reset), 32'(e.pr));
      chk("flush_ack", 32'(flush_ack), 32'(e.pr));
      chk("dec_reset", 32'(dec_reset), 32'(e.dr));
      chk("exc_req", 32'(exc_req), 32'(e.xr));
      chk("seq_busy", 32'(seq_busy), 32'(e.busy));
      chk("prefetch_eip", prefetch_eip, e.pe);
      chk("exc_vector", 32'(exc_vector), 32'(e.vec));
      chk("exc_eip", exc_eip, e.xeip);
      chk("dec_instr_count", dec_instr_count, e.cnt);
    end
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_dec_reset"}, 32'(dec_reset), 32'd0);
    chk({tag, "_pr_reset"}, 32'(pr_reset), 32'd0);
    chk({tag, "_flush_ack"}, 32'(flush_ack), 32'd0);
    chk({tag, "_exc_req"}, 32'(exc_req), 32'd0);
    chk({tag, "_seq_busy"}, 32'(seq_busy), 32'd0);
    chk({tag, "_prefetch_eip"}, prefetch_eip, RESET_EIP);
    chk({tag, "_exc_vector"}, 32'(exc_vector), 32'd0);
    chk({tag, "_exc_eip"}, exc_eip, 32'd0);
    chk({tag, "_count"}, dec_instr_count, 32'd0);
  endtask

  initial begin
    int wait_cyc;
    model_reset();
    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, '0, 0, 0, '0, 0, 0, 0, 0);
    idle(3, 0);

    // basic flush then refill
    drive(1, 32'h00401000, 0, 0, '0, 0, 0, 0, 0);
    idle(4, 0);
    drive(0, '0, 4, 0, '0, 0, 0, 0, 0);
    idle(2, 4);

    // back-to-back flush
    drive(1, 32'h00001000, 0, 0, '0, 0, 0, 0, 0);
    drive(1, 32'h00002000, 0, 0, '0, 0, 0, 0, 0);
    idle(4, 0);
    idle(2, 4);

    // fault priority, ack, parked with sticky faults
    drive(0, '0, 4, 0, 32'h0000ABCD, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) drive(0, '0, 4, 0, 32'h1111, 1, 0, 1, 0);
    drive(0, '0, 4, 0, 32'h2222, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) drive(0, '0, 4, 1, 32'h3333, 1, 1, 1, 0);
    drive(1, 32'h00003000, 0, 0, '0, 0, 0, 0, 0);
    idle(3, 0);
    idle(2, 4);

    // flush beats fault; flush while in FAULT
    drive(1, 32'h00004000, 4, 0, 32'h5555, 0, 1, 0, 0);
    idle(3, 0);
    idle(2, 4);
    drive(0, '0, 4, 0, 32'h6666, 0, 1, 0, 0);
    drive(0, '0, 4, 0, 32'h6666, 0, 1, 0, 0);
    drive(1, 32'h00005000, 4, 0, '0, 0, 1, 0, 1);
    idle(3, 0);
    idle(2, 4);

    // counter: 5 in RUN, 2 during FLUSH
    for (int i = 0; i < 5; i++) drive(0, '0, 4, 1, '0, 0, 0, 0, 0);
    drive(1, 32'h00006000, 0, 0, '0, 0, 0, 0, 0);
    drive(0, '0, 0, 1, '0, 0, 0, 0, 0);
    drive(0, '0, 0, 1, '0, 0, 0, 0, 0);
    idle(1, 0);
    idle(2, 4);

    // counter wrap from a preloaded value
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFE;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    apply(0, '0, 4, 1, '0, 0, 0, 0, 0);
    drive(0, '0, 4, 1, '0, 0, 0, 0, 0);
    drive(0, '0, 4, 1, '0, 0, 0, 0, 0);
    idle(1, 4);

    // async reset mid-FLUSH, between edges
    drive(1, 32'h00007000, 0, 0, '0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, '0, 0, 0, '0, 0, 0, 0, 0);
    idle(2, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit fr, rdy, gp, ud, pf, ack;
      logic [3:0] fv;
      fr  = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 1) == 1);
      gp  = ($urandom_range(0, 99) < 3);
      ud  = ($urandom_range(0, 99) < 3);
      pf  = ($urandom_range(0, 99) < 3);
      ack = ($urandom_range(0, 99) < 25);
      fv  = ($urandom_range(0, 99) < 60) ? 4'd0 : 4'($urandom_range(1, 15));
      drive(fr, $urandom, fv, rdy, $urandom, gp, ud, pf, ack);
    end
    idle(1, 4);

    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0",
               sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
